// File: rtl/core_ctrl_pkg.sv
// rtl/core_ctrl_pkg.sv - instruction word layout and sequencer state encoding
package core_ctrl_pkg;

    localparam int INST_W  = 64;
    localparam int ADDR_FW = 11;

    localparam int B_OS         = 36;
    localparam int B_REN_PMEM   = 35;
    localparam int B_PASSTHRU   = 34;
    localparam int B_ACC        = 33;
    localparam int B_CEN_PMEM   = 32;
    localparam int B_WEN_PMEM   = 31;
    localparam int B_A_PMEM     = 20;
    localparam int B_CEN_XMEM   = 19;
    localparam int B_WEN_XMEM   = 18;
    localparam int B_A_XMEM     = 7;
    localparam int B_OFIFO_RD   = 6;
    localparam int B_IFIFO_WR   = 5;
    localparam int B_IFIFO_RD   = 4;
    localparam int B_L0_RD      = 3;
    localparam int B_L0_WR      = 2;
    localparam int B_EXECUTE    = 1;
    localparam int B_LOAD       = 0;

    localparam logic [INST_W-1:0] IDLE_INST =
        (64'd1 << B_CEN_XMEM) | (64'd1 << B_WEN_XMEM) |
        (64'd1 << B_CEN_PMEM) | (64'd1 << B_WEN_PMEM);

    typedef enum logic [3:0] {
        IDLE, W_L0, W_ARR, GAP, A_L0, EXEC, DRAIN, RDOUT_RD, RDOUT_WR
    } state_t;

    typedef struct packed {
        logic               ren_pmem;
        logic               passthrough;
        logic               acc;
        logic               cen_pmem;
        logic               wen_pmem;
        logic [ADDR_FW-1:0] a_pmem;
        logic               cen_xmem;
        logic               wen_xmem;
        logic [ADDR_FW-1:0] a_xmem;
        logic               ofifo_rd;
        logic               ififo_wr;
        logic               ififo_rd;
        logic               l0_rd;
        logic               l0_wr;
        logic               execute;
        logic               load;
    } inst_fields_t;

    function automatic inst_fields_t idle_fields();
        inst_fields_t f;
        f          = '0;
        f.cen_xmem = 1'b1;
        f.wen_xmem = 1'b1;
        f.cen_pmem = 1'b1;
        f.wen_pmem = 1'b1;
        return f;
    endfunction

endpackage

// File: rtl/core_inst_pack.sv
// rtl/core_inst_pack.sv - maps named control fields onto the 64-bit instruction word
module core_inst_pack
    import core_ctrl_pkg::*;
(
    input  inst_fields_t      f,
    output logic [INST_W-1:0] inst
);

    always_comb begin
        inst                          = '0;
        inst[B_OS]                    = 1'b0;
        inst[B_REN_PMEM]              = f.ren_pmem;
        inst[B_PASSTHRU]              = f.passthrough;
        inst[B_ACC]                   = f.acc;
        inst[B_CEN_PMEM]              = f.cen_pmem;
        inst[B_WEN_PMEM]              = f.wen_pmem;
        inst[B_A_PMEM +: ADDR_FW]     = f.a_pmem;
        inst[B_CEN_XMEM]              = f.cen_xmem;
        inst[B_WEN_XMEM]              = f.wen_xmem;
        inst[B_A_XMEM +: ADDR_FW]     = f.a_xmem;
        inst[B_OFIFO_RD]              = f.ofifo_rd;
        inst[B_IFIFO_WR]              = f.ififo_wr;
        inst[B_IFIFO_RD]              = f.ififo_rd;
        inst[B_L0_RD]                 = f.l0_rd;
        inst[B_L0_WR]                 = f.l0_wr;
        inst[B_EXECUTE]               = f.execute;
        inst[B_LOAD]                  = f.load;
    end

endmodule

// File: rtl/core_inst_seq.sv
// rtl/core_inst_seq.sv - per-layer instruction sequencer driving the core instruction bus
module core_inst_seq
    import core_ctrl_pkg::*;
#(
    parameter int row    = 8,
    parameter int col    = 8,
    parameter int addr_w = 11,
    parameter int nij_w  = 11,
    parameter int kij_w  = 4
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [addr_w-1:0] cfg_w_base,
    input  logic [addr_w-1:0] cfg_a_base,
    input  logic [addr_w-1:0] cfg_p_base,
    input  logic [nij_w-1:0]  cfg_nij,
    input  logic [kij_w-1:0]  cfg_nkij,
    input  logic              ofifo_valid,
    output logic [63:0]       inst,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = nij_w + 1;
    localparam logic [CNT_W-1:0]  CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ROW      = CNT_W'(row);
    localparam logic [CNT_W-1:0]  CNT_COL_LAST = CNT_W'(col - 1);
    localparam logic [nij_w-1:0]  NIJ_ONE      = nij_w'(1);
    localparam logic [kij_w-1:0]  KIJ_ONE      = kij_w'(1);
    localparam logic [addr_w-1:0] ROW_STRIDE   = addr_w'(row);

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [nij_w-1:0]    o_idx, o_idx_n;
    logic [kij_w-1:0]    kij, kij_n;
    logic [addr_w-1:0]   waddr, waddr_n;
    logic                stall, stall_n;
    logic [addr_w-1:0]   a_base, p_base;
    logic [nij_w-1:0]    nij;
    logic [kij_w-1:0]    nkij;
    logic                cfg_load;
    logic                done_n;
    logic [CNT_W-1:0]    cnt_nij;
    inst_fields_t        f;
    logic [INST_W-1:0]   inst_n;

    assign cnt_nij = {1'b0, nij};

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        o_idx_n  = o_idx;
        kij_n    = kij;
        waddr_n  = waddr;
        stall_n  = stall;
        cfg_load = 1'b0;
        case (state)
            IDLE: if (start && cfg_nij != '0 && cfg_nkij != '0) begin
                cfg_load = 1'b1;
                state_n  = W_L0;
                cnt_n    = '0;
                kij_n    = '0;
                o_idx_n  = '0;
                stall_n  = 1'b0;
                waddr_n  = cfg_w_base;
            end
            W_L0: if (cnt == CNT_ROW) begin
                state_n = W_ARR;
                cnt_n   = '0;
            end else cnt_n = cnt + CNT_ONE;
            W_ARR: if (cnt == CNT_COL_LAST) begin
                state_n = GAP;
                cnt_n   = '0;
            end else cnt_n = cnt + CNT_ONE;
            GAP: state_n = A_L0;
            A_L0: if (cnt == cnt_nij) begin
                state_n = EXEC;
                cnt_n   = '0;
            end else cnt_n = cnt + CNT_ONE;
            EXEC: if (cnt == cnt_nij - CNT_ONE) begin
                state_n = DRAIN;
                cnt_n   = '0;
            end else cnt_n = cnt + CNT_ONE;
            DRAIN: if (ofifo_valid) begin
                o_idx_n = '0;
                stall_n = 1'b0;
                state_n = (kij == '0) ? RDOUT_WR : RDOUT_RD;
            end
            RDOUT_RD: begin
                state_n = RDOUT_WR;
                stall_n = !ofifo_valid;
            end
            // stall means the write for o_idx is still owed to the OFIFO
            RDOUT_WR: if (stall) begin
                stall_n = !ofifo_valid;
            end else if (o_idx == nij - NIJ_ONE) begin
                if (kij + KIJ_ONE == nkij) begin
                    state_n = IDLE;
                end else begin
                    kij_n   = kij + KIJ_ONE;
                    waddr_n = waddr + ROW_STRIDE;
                    cnt_n   = '0;
                    state_n = W_L0;
                end
            end else begin
                o_idx_n = o_idx + NIJ_ONE;
                if (kij == '0) stall_n = !ofifo_valid;
                else           state_n = RDOUT_RD;
            end
            default: state_n = IDLE;
        endcase
    end

    // the word is built from the next state so it lands on the same edge
    always_comb begin
        f = idle_fields();
        case (state_n)
            W_L0: begin
                if (cnt_n < CNT_ROW) begin
                    f.cen_xmem = 1'b0;
                    f.a_xmem   = ADDR_FW'(waddr_n + addr_w'(cnt_n));
                end
                f.l0_wr = (cnt_n != '0);
            end
            W_ARR: begin
                f.l0_rd = 1'b1;
                f.load  = 1'b1;
            end
            A_L0: begin
                if (cnt_n < cnt_nij) begin
                    f.cen_xmem = 1'b0;
                    f.a_xmem   = ADDR_FW'(a_base + addr_w'(cnt_n));
                end
                f.l0_wr = (cnt_n != '0);
            end
            EXEC: begin
                f.l0_rd   = 1'b1;
                f.execute = 1'b1;
            end
            RDOUT_RD: begin
                f.cen_pmem = 1'b0;
                f.ren_pmem = 1'b1;
                f.a_pmem   = ADDR_FW'(p_base + addr_w'(o_idx_n));
            end
            RDOUT_WR: if (!stall_n) begin
                f.cen_pmem    = 1'b0;
                f.wen_pmem    = 1'b0;
                f.ofifo_rd    = 1'b1;
                f.passthrough = (kij_n == '0);
                f.acc         = (kij_n != '0);
                f.a_pmem      = ADDR_FW'(p_base + addr_w'(o_idx_n));
            end
            default: f = idle_fields();
        endcase
    end

    assign done_n = (state_n == RDOUT_WR) && !stall_n &&
                    (o_idx_n == nij - NIJ_ONE) && (kij_n + KIJ_ONE == nkij);

    core_inst_pack u_pack (
        .f    (f),
        .inst (inst_n)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            o_idx  <= '0;
            kij    <= '0;
            waddr  <= '0;
            stall  <= 1'b0;
            a_base <= '0;
            p_base <= '0;
            nij    <= '0;
            nkij   <= '0;
            inst   <= IDLE_INST;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            o_idx  <= o_idx_n;
            kij    <= kij_n;
            waddr  <= waddr_n;
            stall  <= stall_n;
            inst   <= inst_n;
            done   <= done_n;
            if (cfg_load) begin
                a_base <= cfg_a_base;
                p_base <= cfg_p_base;
                nij    <= cfg_nij;
                nkij   <= cfg_nkij;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule
